// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector (registered Mealy).
// Compares the most recent `len` valid input bits against a run-time loaded
// pattern and emits a one-cycle match pulse the cycle after the final bit.
// Matches are counted with saturation.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   din_valid    din is sampled on this edge when 1
//   din          serial input bit
//   cfg_load     one-cycle strobe loading cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  pattern; bit len-1 is expected first, bit 0 last
//   cfg_len      pattern length, legal 1..MAX_LEN
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   count_clr    clears match_count
//   match        registered one-cycle pulse per detected pattern
//   match_count  saturating match counter
//   cfg_err      one-cycle pulse when a cfg_load is rejected
//   fill         number of valid history bits, saturates at active len
module seq_detector_prog #(
    parameter int unsigned         MAX_LEN     = 8,
    parameter int unsigned         LEN_W       = 4,
    parameter int unsigned         CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  RST_PATTERN = MAX_LEN'(8'b0000_1010),
    parameter logic [LEN_W-1:0]    RST_LEN     = LEN_W'(4),
    parameter bit                  RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic [LEN_W-1:0]   fill
);

    // StArmed means fill >= len-1: the next valid bit can complete a pattern.
    typedef enum logic [0:0] {StIdle, StArmed} state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               overlap_q, overlap_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] window;
    logic               cfg_ok;
    logic               hit;

    // Low-len-bits mask of the active pattern length.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // History including the bit sampled on this edge.
    assign window = {history_q[MAX_LEN-2:0], din};
    assign cfg_ok = (cfg_len != '0) && ({1'b0, cfg_len} <= (LEN_W+1)'(MAX_LEN));
    assign hit    = din_valid && !cfg_load && (state_q == StArmed) &&
                    ((window & mask) == (pattern_q & mask));

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        history_d = history_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;
        count_d   = count_q;

        // A cfg_load edge never processes din, even when the load is rejected.
        if (cfg_load) begin
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                history_d = '0;
                fill_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (din_valid) begin
            history_d = window;
            match_d   = hit;
            if (hit && !overlap_q) begin
                fill_d = '0;
            end else if (fill_q < len_q) begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (count_clr) begin
            count_d = hit ? CNT_W'(1) : '0;
        end else if (hit && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end

        state_d = (({1'b0, fill_d} + (LEN_W+1)'(1)) >= {1'b0, len_d}) ? StArmed : StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (RST_LEN <= LEN_W'(1)) ? StArmed : StIdle;
            pattern_q <= RST_PATTERN;
            len_q     <= RST_LEN;
            overlap_q <= RST_OVERLAP;
            history_q <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
            count_q   <= count_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign cfg_err     = cfg_err_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed scenarios followed by
// randomized traffic, all checked against a bit-queue reference model.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               din_valid = 1'b0;
    logic               din = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               count_clr = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic [LEN_W-1:0]   fill;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .match       (match),
        .match_count (match_count),
        .cfg_err     (cfg_err),
        .fill        (fill)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: bits seen since the last restart point (reset, legal
    // load, or non-overlapping hit). A hit is the newest len bits equal to the
    // pattern, oldest bit against pattern[len-1].
    bit         m_bits[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt;
    bit         exp_match;
    bit         exp_err;
    int         exp_fill;

    task automatic model_step(input bit r, input bit v, input bit d, input bit ld,
                              input logic [7:0] pat, input int len, input bit ovl,
                              input bit clr);
        bit h;
        h       = 1'b0;
        exp_err = 1'b0;
        if (r) begin
            m_bits.delete();
            m_pat = 8'b0000_1010;
            m_len = 4;
            m_ovl = 1'b1;
            m_cnt = 0;
        end else begin
            if (ld) begin
                if (len >= 1 && len <= MAX_LEN) begin
                    m_pat = pat;
                    m_len = len;
                    m_ovl = ovl;
                    m_bits.delete();
                end else begin
                    exp_err = 1'b1;
                end
            end else if (v) begin
                m_bits.push_back(d);
                if (m_bits.size() > 64) void'(m_bits.pop_front());
                if (m_bits.size() >= m_len) begin
                    h = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) h = 1'b0;
                end
                if (h && !m_ovl) m_bits.delete();
            end
            if (clr) m_cnt = h ? 1 : 0;
            else if (h && m_cnt < CNT_MAX) m_cnt++;
        end
        exp_match = h;
        exp_fill  = (m_bits.size() < m_len) ? m_bits.size() : m_len;
    endtask

    task automatic cyc(input bit r, input bit v, input bit d, input bit ld,
                       input logic [7:0] pat, input int len, input bit ovl, input bit clr);
        rst         = r;
        din_valid   = v;
        din         = d;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        count_clr   = clr;
        model_step(r, v, d, ld, pat, len & ((1 << LEN_W) - 1), ovl, clr);
        @(posedge clk);
        #1;
        check("match", {31'b0, match}, {31'b0, exp_match});
        check("match_count", 32'(match_count), 32'(m_cnt));
        check("cfg_err", {31'b0, cfg_err}, {31'b0, exp_err});
        check("fill", 32'(fill), 32'(exp_fill));
    endtask

    task automatic send(input bit d);
        cyc(1'b0, 1'b1, d, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask
    task automatic send_clr(input bit d);
        cyc(1'b0, 1'b1, d, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    endtask
    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask
    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask
    task automatic load(input logic [7:0] pat, input int len, input bit ovl, input bit clr);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, pat, len, ovl, clr);
    endtask

    initial begin
        logic [7:0] p3;
        p3 = 8'b1100_1101;

        // 1: reset defaults, overlapping 1010
        do_reset();
        check("t1_reset_fill", 32'(fill), 0);
        for (int i = 0; i < 6; i++) send(i % 2 == 0);
        check("t1_count", 32'(match_count), 2);

        // 2: non-overlapping 1010
        load(8'b0000_1010, 4, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send(i % 2 == 0);
        check("t2_count_a", 32'(match_count), 2);
        for (int i = 0; i < 6; i++) send(i % 2 == 0);
        check("t2_count_b", 32'(match_count), 3);

        // 3: 8-bit pattern with valid gaps
        load(p3, 8, 1'b1, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            send(p3[i]);
            if (i == 0) check("t3_match", {31'b0, match}, 1);
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle();
        end
        check("t3_count", 32'(match_count), 1);

        // 4: rejected loads leave the default config in place
        do_reset();
        load(8'hff, 0, 1'b0, 1'b0);
        check("t4_err_len0", {31'b0, cfg_err}, 1);
        load(8'hff, 9, 1'b0, 1'b0);
        check("t4_err_len9", {31'b0, cfg_err}, 1);
        for (int i = 0; i < 4; i++) send(i % 2 == 0);
        check("t4_count", 32'(match_count), 1);

        // 5: saturation, then clear coinciding with a hit
        send_clr(1'b1);
        send(1'b0);
        for (int i = 0; i < 40; i++) send(i % 2 == 0);
        check("t5_saturate", 32'(match_count), CNT_MAX);
        send(1'b1);
        send_clr(1'b0);
        check("t5_clr_hit", 32'(match_count), 1);

        // 6: reset and legal load both discard a partial pattern
        send(1'b1); send(1'b0); send(1'b1);
        do_reset();
        send(1'b0);
        check("t6_rst_nomatch", {31'b0, match}, 0);
        check("t6_rst_count", 32'(match_count), 0);
        send(1'b1); send(1'b0); send(1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'b0000_1010, 4, 1'b1, 1'b0);
        send(1'b0);
        check("t6_load_nomatch", {31'b0, match}, 0);
        check("t6_load_count", 32'(match_count), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = int'($urandom_range(0, 199));
            if (sel == 0) begin
                do_reset();
            end else if (sel < 6) begin
                cyc(1'b0, 1'($urandom), 1'($urandom), 1'b1, 8'($urandom),
                    int'($urandom_range(0, 11)), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            end else begin
                cyc(1'b0, $urandom_range(0, 3) != 0, 1'($urandom), 1'b0, 8'h00, 0, 1'b0,
                    $urandom_range(0, 40) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Programmable Mealy-style serial pattern detector. It is the parametrised successor of the fixed 1010 button-sequence detector. Pattern, length and overlap mode are run-time configurable, input is qualified by a valid strobe, and detected matches are counted with saturation. It sits behind the debounced button/serial-bit front end and drives match indication to the LED/status logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, 4, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match_count
RST_PATTERN, 8'b0000_1010, pattern loaded at reset (LSB-aligned)
RST_LEN, 4, pattern length loaded at reset
RST_OVERLAP, 1, overlap mode loaded at reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
din_valid  in  1  din is sampled on this edge when 1
din  in  1  serial input bit
cfg_load  in  1  one-cycle strobe: load cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  in  MAX_LEN  pattern; bit len-1 is the first bit expected, bit 0 the last
cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
count_clr  in  1  clears match_count
match  out  1  registered one-cycle pulse per detected pattern
match_count  out  CNT_W  saturating number of matches
cfg_err  out  1  one-cycle pulse: cfg_load rejected
fill  out  LEN_W  number of valid history bits, saturates at active len

Behaviour:
- Clock is clk; reset is synchronous, active-high, named rst. Reset dominates all other inputs.
- Reset values: match=0, match_count=0, cfg_err=0, fill=0, history=0. Active config is RST_PATTERN/RST_LEN/RST_OVERLAP. match never resets to X.
- History: MAX_LEN-bit shift register. On each edge with din_valid=1, history <= {history[MAX_LEN-2:0], din}. Edges with din_valid=0 leave history, fill and match state unchanged, and match is driven 0.
- Hit condition, evaluated on a valid edge: fill >= len-1, and ({history, din} masked to the low len bits) == (pattern masked to the low len bits).
- Latency: match=1 in the cycle after the edge that sampled the final pattern bit. This is the same registered-Mealy timing as the existing detector. match is high for exactly one cycle per hit.
- fill: increments by 1 on a valid edge and saturates at len.
  - Overlap=1: fill is unaffected by a hit. The history continues, so a suffix can start the next match.
  - Overlap=0: a hit sets fill=0. History bits remain but are ignored until fill reaches len-1 again.
- cfg_load with 1 <= cfg_len <= MAX_LEN: active config updates on that edge. history and fill are cleared, and match=0 next cycle. A din sample on the same edge is discarded. Config takes effect for the bit sampled on the following valid edge.
- cfg_load with cfg_len=0 or cfg_len>MAX_LEN: config is unchanged, history and fill are untouched, and cfg_err=1 for one cycle.
- cfg_len=1: every valid din equal to pattern[0] produces a match.
- match_count: increments on each hit and saturates at 2^CNT_W-1, with no wrap.
  - count_clr alone sets it to 0.
  - count_clr on the same edge as a hit sets it to 1.
- Priority order: rst > cfg_load > din_valid processing. count_clr is independent of cfg_load.
- Implementation: one control FSM, IDLE (fill<len-1) → ARMED (fill>=len-1) → back, plus the datapath above. Fully synthesizable, with no latches and no combinational output paths.

Test Plan:
1. Reset defaults (1010, overlap). Stream din=1,0,1,0,1,0, all valid → match pulses the cycle after bit 4 and after bit 6; match_count=2.
2. Load pattern 1010, len 4, overlap=0. Stream 1,0,1,0,1,0,1,0 → matches after bits 4 and 8 only; match_count=2. Stream 1,0,1,0,1,0 → a single match.
3. Load 8'b1100_1101, len 8. Stream the pattern with din_valid=0 gaps of 1–3 cycles between bits → exactly one match, one cycle after the last valid bit; no match during gaps.
4. Issue cfg_load with cfg_len=0, then cfg_len=9 (MAX_LEN=8) → cfg_err pulses each time; the default 1010 still detects.
5. CNT_W=4. Feed 20 overlapping 1010 matches → match_count holds at 15. Assert count_clr together with the next match → match_count=1.
6. Assert rst while history holds 101 and then release. Feed 0 → no match. Assert cfg_load mid-pattern, after 1,0,1 → the following 0 produces no match; match_count is unchanged.
